// File: rtl/i2c_reg_bank_if.sv
// Received-byte stream from the I2C slave receiver into the register bank.
interface i2c_reg_bank_if;
  logic [7:0] data_i;
  logic       data_valid_i;
  logic       start_i;
  logic       stop_i;

  modport master (output data_i, output data_valid_i, output start_i, output stop_i);
  modport slave  (input  data_i, input  data_valid_i, input  start_i, input  stop_i);
endinterface

// File: rtl/i2c_reg_bank.sv
// Register bank written by I2C write transactions: pointer byte, then data bytes with
// pointer auto-increment; contents exposed through a combinational read port.
module i2c_reg_bank #(
  parameter int         NUM_REGS  = 8,
  parameter int         ADDR_W    = 3,
  parameter bit         WRAP      = 1'b1,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  i2c_reg_bank_if.slave     rx,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [7:0]        rd_data_o,
  output logic              wr_strobe_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PTR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [1:0]        state;
  logic              dv_q;
  logic              byte_ev;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        regs [NUM_REGS];

  // data_valid_i is a level that may persist for many cycles; only its rising edge is a byte.
  assign byte_ev = rx.data_valid_i & ~dv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      dv_q        <= 1'b0;
      ptr         <= '0;
      wr_strobe_o <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= 8'h00;
      err_o       <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      dv_q        <= rx.data_valid_i;
      wr_strobe_o <= 1'b0;
      if (rx.start_i) begin
        state <= S_PTR;
        err_o <= 1'b0;
      end else if (rx.stop_i) begin
        state <= S_IDLE;
      end else if (byte_ev) begin
        case (state)
          S_PTR: begin
            // Range check on the full byte so e.g. 0x09 is rejected rather than aliased to 1.
            if (int'(rx.data_i) < NUM_REGS) begin
              ptr   <= rx.data_i[ADDR_W-1:0];
              state <= S_DATA;
            end else begin
              err_o <= 1'b1;
              state <= S_DROP;
            end
          end
          S_DATA: begin
            regs[ptr]   <= rx.data_i;
            wr_strobe_o <= 1'b1;
            wr_addr_o   <= ptr;
            wr_data_o   <= rx.data_i;
            if (!WRAP && (ptr == LAST_IDX)) state <= S_DROP;
            else                            ptr   <= ptr + 1'b1;
          end
          S_DROP: err_o <= 1'b1;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign rd_data_o = regs[rd_addr_i];
  assign ptr_o     = ptr;
  assign busy_o    = (state != S_IDLE);

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Bench for i2c_reg_bank: a WRAP=1 and a WRAP=0 instance share one byte stream and are
// compared against a transaction-level model of the register bank.
module tb_i2c_reg_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  i2c_reg_bank_if bus ();

  logic [2:0] rd_addr;
  logic [7:0] rd_data   [2];
  logic       wr_strobe [2];
  logic [2:0] wr_addr   [2];
  logic [7:0] wr_data   [2];
  logic [2:0] ptr       [2];
  logic       busy      [2];
  logic       err       [2];

  i2c_reg_bank #(.NUM_REGS(8), .ADDR_W(3), .WRAP(1'b1), .RESET_VAL(8'h00)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .rx(bus), .rd_addr_i(rd_addr), .rd_data_o(rd_data[0]),
    .wr_strobe_o(wr_strobe[0]), .wr_addr_o(wr_addr[0]), .wr_data_o(wr_data[0]),
    .ptr_o(ptr[0]), .busy_o(busy[0]), .err_o(err[0]));

  i2c_reg_bank #(.NUM_REGS(8), .ADDR_W(3), .WRAP(1'b0), .RESET_VAL(8'h00)) dut_nowrap (
    .clk(clk), .rst_n(rst_n), .rx(bus), .rd_addr_i(rd_addr), .rd_data_o(rd_data[1]),
    .wr_strobe_o(wr_strobe[1]), .wr_addr_o(wr_addr[1]), .wr_data_o(wr_data[1]),
    .ptr_o(ptr[1]), .busy_o(busy[1]), .err_o(err[1]));

  int checks = 0;
  int errors = 0;

  // Model: per instance (0 = wrapping, 1 = non-wrapping) the register image, pointer,
  // sticky error and where we are in the transaction.
  // phase: 0 no transaction, 1 next byte is the pointer, 2 bytes are data, 3 bytes discarded
  logic [7:0] m_regs [2][8];
  int         m_ptr   [2];
  bit         m_err   [2];
  int         m_phase [2];
  bit         exp_wr   [2];
  int         exp_addr [2];
  int         exp_data [2];
  int         strobe_cnt [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) if (wr_strobe[k] === 1'b1) strobe_cnt[k]++;
  end

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 8; a++) m_regs[k][a] = 8'h00;
      m_ptr[k] = 0; m_err[k] = 0; m_phase[k] = 0; exp_wr[k] = 0;
    end
  endtask

  task automatic model_byte(input int b);
    for (int k = 0; k < 2; k++) begin
      exp_wr[k] = 0;
      if (m_phase[k] == 1) begin
        if (b < 8) begin m_ptr[k] = b; m_phase[k] = 2; end
        else begin m_err[k] = 1; m_phase[k] = 3; end
      end else if (m_phase[k] == 2) begin
        exp_wr[k] = 1; exp_addr[k] = m_ptr[k]; exp_data[k] = b;
        m_regs[k][m_ptr[k]] = 8'(b);
        if (k == 1 && m_ptr[k] == 7) m_phase[k] = 3;
        else m_ptr[k] = (m_ptr[k] + 1) % 8;
      end else if (m_phase[k] == 3) begin
        m_err[k] = 1;
      end
    end
  endtask

  task automatic check_state();
    for (int k = 0; k < 2; k++) begin
      check("ptr", k, 32'(ptr[k]), 32'(m_ptr[k]));
      check("err", k, 32'(err[k]), 32'(m_err[k]));
      check("busy", k, 32'(busy[k]), 32'(m_phase[k] != 0));
    end
  endtask

  task automatic sweep();
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #0.5;
      for (int k = 0; k < 2; k++) check("rd_data", k, 32'(rd_data[k]), 32'(m_regs[k][a]));
    end
  endtask

  task automatic send_byte(input int b, input int hold);
    @(negedge clk);
    bus.data_i = 8'(b); bus.data_valid_i = 1'b1;
    model_byte(b);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("wr_strobe", k, 32'(wr_strobe[k]), 32'(exp_wr[k]));
      if (exp_wr[k]) begin
        check("wr_addr", k, 32'(wr_addr[k]), 32'(exp_addr[k]));
        check("wr_data", k, 32'(wr_data[k]), 32'(exp_data[k]));
      end
    end
    check_state();
    @(negedge clk);
    for (int k = 0; k < 2; k++) check("strobe_width", k, 32'(wr_strobe[k]), 32'd0);
    repeat (hold - 2) @(negedge clk);
    bus.data_valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start(input bit with_byte, input int b);
    @(negedge clk);
    bus.start_i = 1'b1;
    if (with_byte) begin bus.data_i = 8'(b); bus.data_valid_i = 1'b1; end
    for (int k = 0; k < 2; k++) begin m_phase[k] = 1; m_err[k] = 0; end
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int k = 0; k < 2; k++) check("start_no_wr", k, 32'(wr_strobe[k]), 32'd0);
    check_state();
    if (with_byte) begin
      @(negedge clk);
      bus.data_valid_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    bus.stop_i = 1'b1;
    for (int k = 0; k < 2; k++) m_phase[k] = 0;
    @(negedge clk);
    bus.stop_i = 1'b0;
    check_state();
  endtask

  initial begin
    int c0, c1, op;
    bus.data_i = 8'h00; bus.data_valid_i = 1'b0; bus.start_i = 1'b0; bus.stop_i = 1'b0;
    rd_addr = 3'd0;
    for (int k = 0; k < 2; k++) strobe_cnt[k] = 0;
    model_reset();

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) check("rst_strobe", k, 32'(wr_strobe[k]), 32'd0);
    check_state();
    sweep();
    @(negedge clk);
    rst_n = 1'b1;

    // Bytes with no START are ignored.
    send_byte(8'h12, 3);
    send_byte(8'h03, 2);
    sweep();

    // Pointer 2, two data bytes, data_valid held 20 cycles each.
    c0 = strobe_cnt[0]; c1 = strobe_cnt[1];
    pulse_start(1'b0, 0);
    send_byte(8'h02, 20);
    send_byte(8'hAA, 20);
    send_byte(8'hBB, 20);
    pulse_stop();
    check("two_strobes", 0, 32'(strobe_cnt[0] - c0), 32'd2);
    check("two_strobes", 1, 32'(strobe_cnt[1] - c1), 32'd2);
    sweep();

    // Write across the last register: wraps on one instance, overflows on the other.
    pulse_start(1'b0, 0);
    send_byte(8'h07, 3);
    send_byte(8'h11, 3);
    send_byte(8'h22, 3);
    pulse_stop();
    sweep();

    // Out-of-range pointer, then a START clears the error.
    pulse_start(1'b0, 0);
    send_byte(8'h09, 2);
    send_byte(8'h55, 2);
    pulse_start(1'b0, 0);
    send_byte(8'h01, 2);
    send_byte(8'h33, 2);
    pulse_start(1'b0, 0);
    send_byte(8'h05, 2);
    send_byte(8'h44, 2);
    pulse_stop();
    sweep();

    // START coincident with a byte: the byte is discarded.
    pulse_start(1'b0, 0);
    send_byte(8'h03, 2);
    pulse_start(1'b1, 8'h66);
    send_byte(8'h04, 2);
    send_byte(8'h99, 2);
    pulse_stop();
    sweep();

    // Randomized transactions.
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 9);
      if (op == 0)      pulse_start(1'b0, 0);
      else if (op == 1) pulse_stop();
      else if (op == 2) pulse_start(1'b1, $urandom_range(0, 255));
      else if (op < 6)  send_byte($urandom_range(0, 7), $urandom_range(2, 6));
      else              send_byte($urandom_range(0, 255), $urandom_range(2, 6));
    end
    pulse_stop();
    sweep();

    // Asynchronous reset mid-DATA while a write strobe is high.
    pulse_start(1'b0, 0);
    send_byte(8'h07, 2);
    send_byte(8'h10, 2);
    send_byte(8'h20, 2);
    @(negedge clk);
    bus.data_i = 8'h77; bus.data_valid_i = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_strobe", 0, 32'(wr_strobe[0]), 32'd1);
    check("pre_rst_err", 1, 32'(err[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) check("async_rst_strobe", k, 32'(wr_strobe[k]), 32'd0);
    check_state();
    sweep();
    bus.data_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h04, 2);
    sweep();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
